// File: rtl/serial_word_feeder.sv
// serial_word_feeder: accepts a parallel word and streams it LSB-first behind a one-cycle clear pulse
module serial_word_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_clr,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CLR, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_bit_q, ser_bit_d, ser_clr_q, ser_clr_d, ser_valid_q, ser_valid_d;
  logic             ser_last_q, ser_last_d, busy_q, busy_d;
  logic             last_bit, accept;
  assign last_bit = state_q == SHIFT && cnt_q == CW'(WIDTH - 1);
  assign in_ready = !reset && (state_q == IDLE || last_bit);
  assign accept   = in_valid && in_ready;
  // Output flops are loaded one cycle ahead, so shreg always holds the bits not yet presented
  always_comb begin
    state_d     = IDLE;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    ser_bit_d   = 1'b0;
    ser_clr_d   = 1'b0;
    ser_valid_d = 1'b0;
    ser_last_d  = 1'b0;
    busy_d      = 1'b0;
    if (accept) begin
      state_d   = CLR;
      shreg_d   = in_data;
      cnt_d     = '0;
      ser_clr_d = 1'b1;
      busy_d    = 1'b1;
    end else if (state_q == CLR || (state_q == SHIFT && !last_bit)) begin
      state_d     = SHIFT;
      cnt_d       = state_q == CLR ? cnt_q : cnt_q + 1'b1;
      shreg_d     = shreg_q >> 1;
      ser_bit_d   = shreg_q[0];
      ser_valid_d = 1'b1;
      ser_last_d  = cnt_d == CW'(WIDTH - 1);
      busy_d      = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      ser_bit_q   <= 1'b0;
      ser_clr_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      ser_bit_q   <= ser_bit_d;
      ser_clr_q   <= ser_clr_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
      busy_q      <= busy_d;
    end
  end
  assign ser_bit   = ser_bit_q;
  assign ser_clr   = ser_clr_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_serial_word_feeder.sv
// tb_serial_word_feeder: directed checks of the serial feeder with a behavioural two's-complement converter
module tb_serial_word_feeder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, ser_bit, ser_clr, ser_valid, ser_last, busy;
  logic [1:0] in_data2 = '0;
  logic       in_valid2 = 1'b0;
  logic       in_ready2, ser_bit2, ser_clr2, ser_valid2, ser_last2, busy2;
  int         n_chk = 0;
  int         n_fail = 0;
  serial_word_feeder #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ser_bit(ser_bit), .ser_clr(ser_clr), .ser_valid(ser_valid), .ser_last(ser_last), .busy(busy)
  );
  serial_word_feeder #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .ser_bit(ser_bit2), .ser_clr(ser_clr2), .ser_valid(ser_valid2), .ser_last(ser_last2), .busy(busy2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Converter model: copy bits up to and including the first 1, invert every bit after it
  logic [7:0] sh, cv;
  logic       seen = 1'b0;
  int         nb = 0;
  logic [7:0] words[$];
  logic [7:0] convs[$];
  int         lens[$];
  always @(negedge clk) begin
    if (ser_clr) begin
      nb = 0;
      seen = 1'b0;
    end
    if (ser_valid) begin
      if (nb < 8) begin
        sh[nb] = ser_bit;
        cv[nb] = ser_bit ^ seen;
      end
      seen = seen | ser_bit;
      nb++;
      if (ser_last) begin
        words.push_back(sh);
        convs.push_back(cv);
        lens.push_back(nb);
      end
    end
  end
  task automatic xfer(input logic [7:0] w, input bit hold, input bit toggle);
    in_data = w;
    in_valid = 1'b1;
    tick();
    in_valid = hold;
    check("clr", ser_clr, 1);
    check("clr_valid", ser_valid, 0);
    check("clr_ready", in_ready, 0);
    check("clr_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      if (toggle) in_data = ~in_data;
      tick();
      check($sformatf("bit%0d_%02h", i, w), ser_bit, w[i]);
      check($sformatf("valid%0d", i), ser_valid, 1);
      check($sformatf("last%0d", i), ser_last, i == 7);
      check($sformatf("ready%0d", i), in_ready, i == 7);
      check($sformatf("clr%0d", i), ser_clr, 0);
    end
  endtask
  task automatic idle_check(input string tag);
    in_valid = 1'b0;
    tick();
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, ser_valid, 0);
    check({tag, "_ready"}, in_ready, 1);
  endtask
  task automatic expect_word(input string tag, input logic [7:0] w, input logic [7:0] c);
    check({tag, "_n"}, words.size() != 0, 1);
    if (words.size() != 0) begin
      check({tag, "_word"}, words.pop_front(), w);
      check({tag, "_conv"}, convs.pop_front(), c);
      check({tag, "_len"}, lens.pop_front(), 8);
    end
  endtask
  logic [3:0] exp2[7] = '{4'b1000, 4'b0100, 4'b0111, 4'b1000, 4'b0110, 4'b0101, 4'b0000};
  initial begin
    in_valid = 1'b1;
    in_data = 8'h77;
    tick();
    tick();
    check("rst_ready", in_ready, 0);
    check("rst_clr", ser_clr, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1);
    check("post_rst_clr", ser_clr, 0);
    check("post_rst_valid", ser_valid, 0);
    xfer(8'h06, 0, 0);
    idle_check("w06");
    expect_word("w06", 8'h06, 8'hFA);
    xfer(8'h01, 1, 0);
    xfer(8'h80, 1, 0);
    idle_check("b2b");
    expect_word("b2b1", 8'h01, 8'hFF);
    expect_word("b2b2", 8'h80, 8'h80);
    xfer(8'h5A, 1, 1);
    idle_check("tog");
    expect_word("tog", 8'h5A, 8'hA6);
    in_data = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("a5_bit3", ser_bit, 0);
    check("a5_valid3", ser_valid, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_bit", ser_bit, 0);
    check("mid_rst_clr", ser_clr, 0);
    check("mid_rst_valid", ser_valid, 0);
    check("mid_rst_last", ser_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_ready_after", in_ready, 1);
    xfer(8'h3C, 0, 0);
    idle_check("w3c");
    expect_word("w3c", 8'h3C, 8'hC4);
    check("no_extra", words.size(), 0);
    xfer(8'h00, 0, 0);
    idle_check("w00");
    expect_word("w00", 8'h00, 8'h00);
    xfer(8'hFF, 0, 0);
    idle_check("wff");
    expect_word("wff", 8'hFF, 8'h01);
    in_data2 = 2'b10;
    in_valid2 = 1'b1;
    tick();
    for (int c = 0; c < 7; c++) begin
      check($sformatf("w2_c%0d", c), {ser_clr2, ser_valid2, ser_bit2, ser_last2}, exp2[c]);
      check($sformatf("w2_ready%0d", c), in_ready2, c == 2 || c == 5 || c == 6);
      if (c == 2) in_data2 = 2'b01;
      if (c == 5) in_valid2 = 1'b0;
      if (c < 6) tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
